led_index_sequencer: RTL and testbench
======================================

Name: led_index_sequencer

Overview:
- Upstream stage of the 4-bit shift decoder on the LED board path.
- Generates the binary LED index and the decoder enable that light one LEDR position at a time.
- Index advances on a prescaled tick (up, down or ping-pong) or on a manual KEY step.
- Run/pause/clear control state machine; registered outputs feed the decoder's binary_in and enable directly.

Parameters:
- INDEX_W, 4, width of index output (matches decoder input width)
- MAX_INDEX, 9, highest index produced (10 LEDs); legal range 1..2**INDEX_W-1
- PRESCALE, 25000000, clock cycles per automatic step; minimum 2

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high; all state cleared on the clock edge where it is sampled high
- run  input  1  level; 1 = sequence running, 0 = pause
- clear  input  1  level; synchronous return to IDLE, index 0
- mode  input  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 manual step
- step_n  input  1  asynchronous active-low push-button (KEY); manual step source
- index  output  INDEX_W  registered LED index, to decoder binary_in
- index_en  output  1  registered decoder enable
- wrap  output  1  one-cycle pulse on wrap-around or ping-pong turnaround

Behaviour:
- Reset values:
  - index = 0, index_en = 0, wrap = 0
  - state = IDLE, dir = up, prescale count = 0
  - synchronizer flops = 1 (released key level)
- step_n path:
  - 2-flop synchronizer, then falling-edge detect gives a 1-cycle step pulse.
  - step_n low at edge N gives a step pulse in cycle N+2; index updates at edge N+3.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN.
  - tick = 1 for the cycle where count == PRESCALE-1; count then returns to 0.
  - Count is cleared whenever state is not RUN, so resuming always waits a full PRESCALE.
- State machine (clear has priority over all transitions):
  - IDLE: index_en = 0, index = 0. run = 1 → RUN.
  - RUN: index_en = 1. run = 0 → PAUSE.
  - PAUSE: index_en = 1, index held. run = 1 → RUN.
  - clear = 1 in any state → IDLE next edge: index = 0, dir = up, wrap = 0.
- Advance event:
  - mode 00/01/10: tick in RUN. Step pulses are ignored.
  - mode 11: step pulse in RUN or PAUSE. Ticks are ignored.
  - Step pulses in IDLE are discarded.
- Index update on an advance event:
  - up (00) and manual (11): index == MAX_INDEX → 0 with wrap = 1, else +1.
  - down (01): index == 0 → MAX_INDEX with wrap = 1, else −1.
  - ping-pong (10), dir up: index == MAX_INDEX → dir = down, index = MAX_INDEX−1, wrap = 1; else +1.
  - ping-pong (10), dir down: index == 0 → dir = up, index = 1, wrap = 1; else −1.
  - wrap is 0 in every cycle without such an event.
- Mode change:
  - Sampled every cycle; takes effect at the next advance event.
  - dir forced to up while mode != 10.
  - No index jump on a mode change.
- Width rules:
  - All arithmetic stays within INDEX_W bits.
  - index never exceeds MAX_INDEX, including when MAX_INDEX = 2**INDEX_W−1 (natural overflow must give 0 exactly at wrap).
- reset or clear asserted mid-sequence: outputs reach reset values at that edge; no wrap pulse is emitted.

Decomposition:
- Shared package holds:
  - mode encodings MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_MANUAL
  - FSM state encodings S_IDLE, S_RUN, S_PAUSE
- One sub-module: key_edge_sync (2-flop synchronizer plus falling-edge pulse); reused for other KEY inputs on the board.
- Prescaler and FSM stay inline.

Test Plan (PRESCALE = 4, MAX_INDEX = 9):
- Up wrap: reset, run = 1, mode = 00.
  - index_en = 1 after 1 cycle.
  - index 0→1 four cycles later, then increments every 4 cycles.
  - 9→0 with wrap = 1 for exactly one cycle.
- Ping-pong: mode = 10, run = 1 for 80 cycles.
  - index sequence 0,1,…,9,8,…,0,1.
  - wrap pulses at the 9→8 and 0→1 turnarounds only.
- Down and pause: mode = 01 from index 0.
  - First tick gives 9 with wrap = 1.
  - run = 0 for 20 cycles: index frozen, index_en stays 1.
  - run = 1: next decrement exactly 4 cycles after resume.
- Manual step: mode = 11, run = 1.
  - Three step_n low pulses (each 3 cycles long) give index 1,2,3, each 3 edges after the falling edge.
  - step_n held low for 50 cycles produces only one step.
  - Ticks cause no change.
- Clear/reset priority:
  - clear = 1 with run = 1 at index 5 → next edge index = 0, index_en = 0, state IDLE.
  - reset asserted in the same cycle as a wrap event → wrap = 0, index = 0.
- Max width: INDEX_W = 4, MAX_INDEX = 15, mode = 00 → 15→0 wrap with wrap = 1; index never exceeds 15.

Source files
------------

// File: rtl/led_index_sequencer_pkg.sv
// Shared encodings for the LED index sequencer: sequencing modes, control states
// and ping-pong direction.
package led_index_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_MANUAL   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_index_sequencer_if.sv
// Control and status bundle between the board controls and the LED index sequencer.
// The slave side is the sequencer; the master side drives run/clear/mode/KEY.
interface led_index_sequencer_if #(
  parameter int INDEX_W = 4
);
  import led_index_sequencer_pkg::*;

  logic               run;
  logic               clear;
  mode_e              mode;
  logic               step_n;
  logic [INDEX_W-1:0] index;
  logic               index_en;
  logic               wrap;

  modport master (
    output run, clear, mode, step_n,
    input  index, index_en, wrap
  );

  modport slave (
    input  run, clear, mode, step_n,
    output index, index_en, wrap
  );

endinterface

// File: rtl/led_index_sequencer_key_edge_sync.sv
// Two-flop synchronizer for an active-low push-button followed by a registered
// falling-edge detector; one pulse per press regardless of how long it is held.
module key_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  logic sync_a;
  logic sync_b;
  logic key_prev;

  // Flops come out of reset at the released level so a held key still counts as a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a   <= 1'b1;
      sync_b   <= 1'b1;
      key_prev <= 1'b1;
      pulse    <= 1'b0;
    end else begin
      sync_a   <= key_n;
      sync_b   <= sync_a;
      key_prev <= sync_b;
      pulse    <= key_prev & ~sync_b;
    end
  end

endmodule

// File: rtl/led_index_sequencer.sv
// Generates the binary LED index and decoder enable for the shift decoder, advancing
// on a prescaled tick (up/down/ping-pong) or on a manual KEY step.
module led_index_sequencer
  import led_index_sequencer_pkg::*;
#(
  parameter int INDEX_W   = 4,
  parameter int MAX_INDEX = 9,
  parameter int PRESCALE  = 25000000
) (
  input logic                  clock,
  input logic                  reset,
  led_index_sequencer_if.slave bus
);

  localparam int                 CNT_W    = $clog2(PRESCALE);
  localparam logic [INDEX_W-1:0] MAX_IDX  = INDEX_W'(MAX_INDEX);
  localparam logic [INDEX_W-1:0] ONE      = INDEX_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  state_e             state;
  dir_e               dir;
  dir_e               adv_dir;
  logic [CNT_W-1:0]   count;
  logic [INDEX_W-1:0] index_q;
  logic [INDEX_W-1:0] adv_index;
  logic               index_en_q;
  logic               wrap_q;
  logic               adv_wrap;
  logic               tick;
  logic               step_pulse;
  logic               advance;

  key_edge_sync u_step_sync (
    .clock (clock),
    .reset (reset),
    .key_n (bus.step_n),
    .pulse (step_pulse)
  );

  assign tick    = (state == S_RUN) && (count == CNT_LAST);
  assign advance = (bus.mode == MODE_MANUAL)
                   ? (step_pulse && ((state == S_RUN) || (state == S_PAUSE)))
                   : tick;

  // Compare against the end points before stepping so MAX_IDX = all-ones never overflows.
  always_comb begin
    adv_index = index_q + ONE;
    adv_wrap  = 1'b0;
    adv_dir   = dir;
    case (bus.mode)
      MODE_DOWN: begin
        if (index_q == '0) begin
          adv_index = MAX_IDX;
          adv_wrap  = 1'b1;
        end else begin
          adv_index = index_q - ONE;
        end
      end
      MODE_PINGPONG: begin
        if (dir == DIR_UP) begin
          if (index_q == MAX_IDX) begin
            adv_index = MAX_IDX - ONE;
            adv_dir   = DIR_DOWN;
            adv_wrap  = 1'b1;
          end
        end else if (index_q == '0) begin
          adv_index = ONE;
          adv_dir   = DIR_UP;
          adv_wrap  = 1'b1;
        end else begin
          adv_index = index_q - ONE;
        end
      end
      default: begin
        if (index_q == MAX_IDX) begin
          adv_index = '0;
          adv_wrap  = 1'b1;
        end
      end
    endcase
  end

  // Control FSM, prescaler and index register; clear overrides every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      dir        <= DIR_UP;
      count      <= '0;
      index_q    <= '0;
      index_en_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else if (bus.clear) begin
      state      <= S_IDLE;
      dir        <= DIR_UP;
      count      <= '0;
      index_q    <= '0;
      index_en_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      count  <= ((state == S_RUN) && !tick) ? count + CNT_ONE : '0;
      if (bus.mode != MODE_PINGPONG) begin
        dir <= DIR_UP;
      end

      case (state)
        S_IDLE: begin
          index_q    <= '0;
          index_en_q <= run_now();
          if (bus.run) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          index_en_q <= 1'b1;
          if (!bus.run) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          index_en_q <= 1'b1;
          if (bus.run) begin
            state <= S_RUN;
          end
        end
        default: begin
          state      <= S_IDLE;
          index_en_q <= 1'b0;
        end
      endcase

      if (advance) begin
        index_q <= adv_index;
        wrap_q  <= adv_wrap;
        if (bus.mode == MODE_PINGPONG) begin
          dir <= adv_dir;
        end
      end
    end
  end

  function automatic logic run_now();
    return bus.run;
  endfunction

  assign bus.index    = index_q;
  assign bus.index_en = index_en_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_led_index_sequencer.sv
// Directed and randomized bench for led_index_sequencer; a MAX_INDEX=9 and a
// MAX_INDEX=15 instance share stimulus and are checked against an arithmetic model.
module tb_led_index_sequencer;
  import led_index_sequencer_pkg::*;

  localparam int PRESCALE = 4;

  logic clock;
  logic reset;

  logic       drv_reset;
  logic       drv_run;
  logic       drv_clear;
  logic [1:0] drv_mode;
  logic       drv_step_n;

  int pass_count  = 0;
  int total_count = 0;
  int fail_count  = 0;
  int wrap_seen0  = 0;
  int wrap_seen1  = 0;

  int max_of[2] = '{9, 15};
  int m_idx[2];
  int m_dir[2];
  bit m_wrap[2];
  bit m_active;
  bit m_running;
  int m_cnt;
  bit key_hist[4];

  led_index_sequencer_if #(.INDEX_W(4)) bus0 ();
  led_index_sequencer_if #(.INDEX_W(4)) bus1 ();

  led_index_sequencer #(.INDEX_W(4), .MAX_INDEX(9), .PRESCALE(PRESCALE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  led_index_sequencer #(.INDEX_W(4), .MAX_INDEX(15), .PRESCALE(PRESCALE)) dut_max (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // The KEY pulse lands two cycles after the first low sample, so it is visible
  // here when the sample three edges back was high and the one two edges back low.
  task automatic model_step();
    bit pulse;
    bit tick;
    bit adv;
    pulse = (key_hist[2] == 1'b0) && (key_hist[3] == 1'b1);
    tick  = m_running && (m_cnt == PRESCALE - 1);
    m_wrap = '{1'b0, 1'b0};
    if (drv_reset) begin
      m_active  = 1'b0;
      m_running = 1'b0;
      m_cnt     = 0;
      key_hist  = '{1'b1, 1'b1, 1'b1, 1'b1};
      for (int d = 0; d < 2; d++) begin
        m_idx[d] = 0;
        m_dir[d] = 1;
      end
    end else begin
      key_hist[3] = key_hist[2];
      key_hist[2] = key_hist[1];
      key_hist[1] = key_hist[0];
      key_hist[0] = drv_step_n;
      if (drv_clear) begin
        m_active  = 1'b0;
        m_running = 1'b0;
        m_cnt     = 0;
        for (int d = 0; d < 2; d++) begin
          m_idx[d] = 0;
          m_dir[d] = 1;
        end
      end else begin
        adv   = (drv_mode == 2'd3) ? (pulse && m_active) : tick;
        m_cnt = (m_running && !tick) ? m_cnt + 1 : 0;
        for (int d = 0; d < 2; d++) begin
          if (drv_mode != 2'd2) m_dir[d] = 1;
          if (adv) begin
            case (drv_mode)
              2'd1: begin
                m_idx[d]  = (m_idx[d] + max_of[d]) % (max_of[d] + 1);
                m_wrap[d] = (m_idx[d] == max_of[d]);
              end
              2'd2: begin
                if ((m_idx[d] + m_dir[d] > max_of[d]) || (m_idx[d] + m_dir[d] < 0)) begin
                  m_dir[d]  = -m_dir[d];
                  m_wrap[d] = 1'b1;
                end
                m_idx[d] = m_idx[d] + m_dir[d];
              end
              default: begin
                m_idx[d]  = (m_idx[d] + 1) % (max_of[d] + 1);
                m_wrap[d] = (m_idx[d] == 0);
              end
            endcase
          end
        end
        if (!m_active) begin
          if (drv_run) begin
            m_active  = 1'b1;
            m_running = 1'b1;
          end
        end else begin
          m_running = drv_run;
        end
      end
    end
  endtask

  task automatic applyStimulus();
    reset       = drv_reset;
    bus0.run    = drv_run;
    bus0.clear  = drv_clear;
    bus0.mode   = mode_e'(drv_mode);
    bus0.step_n = drv_step_n;
    bus1.run    = drv_run;
    bus1.clear  = drv_clear;
    bus1.mode   = mode_e'(drv_mode);
    bus1.step_n = drv_step_n;
    @(posedge clock);
    model_step();
    @(negedge clock);
    checkOutput("idx9",   8'(bus0.index),    8'(m_idx[0]));
    checkOutput("en9",    8'(bus0.index_en), 8'(m_active));
    checkOutput("wrap9",  8'(bus0.wrap),     8'(m_wrap[0]));
    checkOutput("idx15",  8'(bus1.index),    8'(m_idx[1]));
    checkOutput("en15",   8'(bus1.index_en), 8'(m_active));
    checkOutput("wrap15", 8'(bus1.wrap),     8'(m_wrap[1]));
    if (bus0.wrap === 1'b1) wrap_seen0++;
    if (bus1.wrap === 1'b1) wrap_seen1++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    drv_reset  = 1'b1;
    drv_run    = 1'b0;
    drv_clear  = 1'b0;
    drv_mode   = 2'd0;
    drv_step_n = 1'b1;

    // Reset values, then up-wrap.
    applyStimulus();
    checkOutput("rst_idx", 8'(bus0.index), 8'd0);
    checkOutput("rst_en", 8'(bus0.index_en), 8'd0);
    checkOutput("rst_wrap", 8'(bus0.wrap), 8'd0);
    drv_reset = 1'b0;
    drv_run   = 1'b1;
    applyStimulus();
    checkOutput("up_en", 8'(bus0.index_en), 8'd1);
    cycles(4);
    checkOutput("up_first", 8'(bus0.index), 8'd1);
    cycles(36);
    checkOutput("up_wrap_idx", 8'(bus0.index), 8'd0);
    checkOutput("up_wrap_pulse", 8'(bus0.wrap), 8'd1);
    cycles(1);
    checkOutput("up_wrap_single", 8'(bus0.wrap), 8'd0);

    // Ping-pong: 20 ticks from 0 bounce off 9 and off 0.
    wrap_seen0 = 0;
    drv_mode   = 2'd2;
    cycles(80);
    checkOutput("pp_wraps", 8'(wrap_seen0), 8'd2);
    checkOutput("pp_idx", 8'(bus0.index), 8'd2);

    // Down and pause.
    drv_clear = 1'b1;
    drv_mode  = 2'd1;
    cycles(1);
    checkOutput("clr_idx", 8'(bus0.index), 8'd0);
    drv_clear = 1'b0;
    cycles(5);
    checkOutput("down_idx", 8'(bus0.index), 8'd9);
    checkOutput("down_wrap", 8'(bus0.wrap), 8'd1);
    drv_run = 1'b0;
    cycles(20);
    checkOutput("pause_idx", 8'(bus0.index), 8'd9);
    checkOutput("pause_en", 8'(bus0.index_en), 8'd1);
    drv_run = 1'b1;
    cycles(4);
    checkOutput("resume_hold", 8'(bus0.index), 8'd9);
    cycles(1);
    checkOutput("resume_step", 8'(bus0.index), 8'd8);

    // Manual steps: index moves three edges after the key falls.
    drv_clear = 1'b1;
    drv_mode  = 2'd3;
    cycles(1);
    drv_clear = 1'b0;
    cycles(1);
    for (int k = 1; k <= 3; k++) begin
      drv_step_n = 1'b0;
      cycles(3);
      checkOutput("man_before", 8'(bus0.index), 8'(k - 1));
      drv_step_n = 1'b1;
      cycles(1);
      checkOutput("man_after", 8'(bus0.index), 8'(k));
      cycles(4);
    end
    drv_step_n = 1'b0;
    cycles(50);
    drv_step_n = 1'b1;
    cycles(5);
    checkOutput("man_hold", 8'(bus0.index), 8'd4);
    drv_step_n = 1'b0;
    drv_reset  = 1'b1;
    cycles(1);
    checkOutput("man_rst_idx", 8'(bus0.index), 8'd0);
    drv_reset = 1'b0;
    cycles(4);
    checkOutput("man_rst_held", 8'(bus0.index), 8'd1);
    drv_step_n = 1'b1;
    cycles(3);

    // Clear and reset priority.
    drv_mode  = 2'd0;
    drv_clear = 1'b1;
    cycles(1);
    drv_clear = 1'b0;
    cycles(21);
    checkOutput("prio_idx5", 8'(bus0.index), 8'd5);
    drv_clear = 1'b1;
    cycles(1);
    checkOutput("prio_clr_idx", 8'(bus0.index), 8'd0);
    checkOutput("prio_clr_en", 8'(bus0.index_en), 8'd0);
    drv_clear = 1'b0;
    cycles(40);
    checkOutput("prio_idx9", 8'(bus0.index), 8'd9);
    drv_reset = 1'b1;
    cycles(1);
    checkOutput("prio_rst_idx", 8'(bus0.index), 8'd0);
    checkOutput("prio_rst_wrap", 8'(bus0.wrap), 8'd0);
    checkOutput("prio_rst_en", 8'(bus0.index_en), 8'd0);
    drv_reset = 1'b0;

    // Full-width wrap on the MAX_INDEX=15 instance.
    cycles(64);
    checkOutput("max_idx15", 8'(bus1.index), 8'd15);
    cycles(1);
    checkOutput("max_wrap_idx", 8'(bus1.index), 8'd0);
    checkOutput("max_wrap_pulse", 8'(bus1.wrap), 8'd1);

    // Randomized mix of run/clear/mode/KEY/reset.
    drv_mode = 2'd3;
    for (int i = 0; i < 400; i++) begin
      drv_reset = ($urandom_range(0, 149) == 0);
      drv_clear = ($urandom_range(0, 39) == 0);
      drv_run   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) drv_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) drv_step_n = ~drv_step_n;
      applyStimulus();
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
